// File: rtl/ed_vga_pkg.sv
// Shared constants and types for the 640x480 VGA frame reader.
package ed_vga_pkg;

  // 640x480@60 horizontal timing in pixel clocks.
  localparam int H_ACTIVE_C = 640;
  localparam int H_FP_C     = 16;
  localparam int H_SYNC_C   = 96;
  localparam int H_BP_C     = 48;
  localparam int H_TOTAL_C  = H_ACTIVE_C + H_FP_C + H_SYNC_C + H_BP_C;

  // Vertical timing in lines.
  localparam int V_ACTIVE_C = 480;
  localparam int V_FP_C     = 10;
  localparam int V_SYNC_C   = 2;
  localparam int V_BP_C     = 33;
  localparam int V_TOTAL_C  = V_ACTIVE_C + V_FP_C + V_SYNC_C + V_BP_C;

  // Source frame buffer geometry (half resolution in both axes).
  localparam int SRC_W_C = 320;
  localparam int SRC_H_C = 240;

  // Overlay colours.
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;

  // Per-pixel control word carried down the pipeline alongside the read.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       hs_n;
    logic       vs_n;
    logic       last;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_IDLE = '{x: 10'd0, y: 10'd0, vis: 1'b0,
                                    hs_n: 1'b1, vs_n: 1'b1, last: 1'b0};

  // 1-based source column that a screen column x replicates.
  function automatic logic [9:0] src_col(input logic [9:0] x);
    return {1'b0, x[9:1]} + 10'd1;
  endfunction

endpackage

// File: rtl/ed_vga_frame_reader_if.sv
// Buffer read port, overlay controls and VGA pins of the frame reader.
interface ed_vga_frame_reader_if;
  logic [16:0] read_addr;
  logic [11:0] data_in;
  logic [9:0]  h_centroid;
  logic        stop_detect;
  logic        overlay_en;
  logic [11:0] vga_rgb;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_done;

  modport master (
    output read_addr, vga_rgb, hsync, vsync, video_on, frame_done,
    input  data_in, h_centroid, stop_detect, overlay_en
  );

  modport slave (
    input  read_addr, vga_rgb, hsync, vsync, video_on, frame_done,
    output data_in, h_centroid, stop_detect, overlay_en
  );
endinterface

// File: rtl/ed_vga_timing.sv
// Raster counters, sync decode and line/frame strobes (pipeline stage S0).
module ed_vga_timing
  import ed_vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_C,
  parameter int H_FP     = H_FP_C,
  parameter int H_SYNC   = H_SYNC_C,
  parameter int H_BP     = H_BP_C,
  parameter int V_ACTIVE = V_ACTIVE_C,
  parameter int V_FP     = V_FP_C,
  parameter int V_SYNC   = V_SYNC_C,
  parameter int V_BP     = V_BP_C
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       visible,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       eol,
  output logic       eof
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  assign eol     = (h_cnt_q == H_LAST);
  assign eof     = eol && (v_cnt_q == V_LAST);
  assign visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync_n = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
  assign vsync_n = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  assign h_cnt   = h_cnt_q;
  assign v_cnt   = v_cnt_q;

  // Next raster position: both counters wrap together at end of frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (eol) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/ed_vga_frame_reader.sv
// Scans the 320x240 binarised buffer out as 640x480 VGA with 2x replication,
// overlaying a centroid marker and a stop border latched once per frame.
module ed_vga_frame_reader
  import ed_vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_C,
  parameter int H_FP       = H_FP_C,
  parameter int H_SYNC     = H_SYNC_C,
  parameter int H_BP       = H_BP_C,
  parameter int V_ACTIVE   = V_ACTIVE_C,
  parameter int V_FP       = V_FP_C,
  parameter int V_SYNC     = V_SYNC_C,
  parameter int V_BP       = V_BP_C,
  parameter int SRC_W      = SRC_W_C,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ed_vga_frame_reader_if.master bus
);

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  X_BORDER  = 10'(H_ACTIVE - 5);
  localparam logic [9:0]  Y_BORDER  = 10'(V_ACTIVE - 5);
  localparam logic [16:0] ROW_STEP  = 17'(SRC_W);

  logic [9:0] h_cnt, v_cnt;
  logic       visible, hsync_n, vsync_n, eol, eof;

  ed_vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (visible),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .eol     (eol),
    .eof     (eof)
  );

  logic [16:0] row_base_q, row_base_d;
  logic [16:0] addr_q, addr_d;
  logic [9:0]  cent_q, cent_d;
  logic        stop_q, stop_d;
  pix_ctl_t    pipe_q [0:RD_LATENCY];
  pix_ctl_t    pipe_d [0:RD_LATENCY];
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, von_q, von_d, fd_q, fd_d;

  // Row base advances after every second visible line so each source row
  // is shown twice; it restarts at the frame wrap.
  always_comb begin
    row_base_d = row_base_q;
    if (eof) begin
      row_base_d = 17'd0;
    end else if (eol && v_cnt[0] && (v_cnt < Y_LAST)) begin
      row_base_d = row_base_q + ROW_STEP;
    end else begin
      row_base_d = row_base_q;
    end
  end

  // Buffer address: 1-based, column halves the screen x; 0 while blanked.
  always_comb begin
    addr_d = 17'd0;
    if (visible) begin
      addr_d = row_base_q + {8'd0, h_cnt[9:1]} + 17'd1;
    end else begin
      addr_d = 17'd0;
    end
  end

  // Overlay inputs are captured only at raster origin so a frame never tears.
  always_comb begin
    cent_d = cent_q;
    stop_d = stop_q;
    if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
      cent_d = bus.h_centroid;
      stop_d = bus.stop_detect;
    end else begin
      cent_d = cent_q;
      stop_d = stop_q;
    end
  end

  // Control pipeline: S1 entry plus one stage per memory latency cycle.
  always_comb begin
    pipe_d[0] = '{x: h_cnt, y: v_cnt, vis: visible, hs_n: hsync_n,
                  vs_n: vsync_n,
                  last: visible && (h_cnt == X_LAST) && (v_cnt == Y_LAST)};
    for (int i = 1; i <= RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Colour select on the pixel whose read data is arriving this cycle.
  always_comb begin
    pix_ctl_t c;
    logic     border;
    c      = pipe_q[RD_LATENCY];
    border = (c.x < 10'd4) || (c.x > X_BORDER) ||
             (c.y < 10'd4) || (c.y > Y_BORDER);
    rgb_d  = BLACK;
    if (!c.vis) begin
      rgb_d = BLACK;
    end else if (bus.overlay_en && stop_q && border) begin
      rgb_d = RED;
    end else if (bus.overlay_en && (cent_q != 10'd0) &&
                 (src_col(c.x) == cent_q)) begin
      rgb_d = GREEN;
    end else begin
      rgb_d = bus.data_in;
    end
    hs_d  = c.hs_n;
    vs_d  = c.vs_n;
    von_d = c.vis;
    fd_d  = c.last;
  end

  // Address, overlay latch and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q <= 17'd0;
      addr_q     <= 17'd0;
      cent_q     <= 10'd0;
      stop_q     <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_q[i] <= CTL_IDLE;
      end
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      cent_q     <= cent_d;
      stop_q     <= stop_d;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Output register driving the VGA pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= BLACK;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.read_addr  = addr_q;
  assign bus.vga_rgb    = rgb_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.video_on   = von_q;
  assign bus.frame_done = fd_q;

endmodule

// File: doc/ed_vga_frame_reader.md
# ed_vga_frame_reader

Reads the 320x240 binarised frame buffer that the edge-detection filter writes and scans it out as 640x480@60 VGA with 2x pixel replication. It also overlays the line centroid marker and a stop-detect border. It is the read-side consumer of the filter's buffer addressing scheme: pixel (h,v), h=1..320, v=1..240, lives at address (v-1)*320 + h, and address 0 is unused. It sits between the display-port frame buffer and the VGA pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths (frame total 525)
- SRC_W, 320, source buffer width
- RD_LATENCY, 1, buffer read latency in cycles (1..2)

Ports:
- clk  in  1  pixel clock (25.175 MHz), one pixel per cycle
- reset  in  1  asynchronous, active-high
- data_in  in  12  buffer read data {R[3:0],G[3:0],B[3:0]}, valid RD_LATENCY cycles after read_addr
- h_centroid  in  10  source-column centroid from filter, 0 = none
- stop_detect  in  1  stop flag from filter
- overlay_en  in  1  enables marker and border overlay
- read_addr  out  17  buffer read address
- vga_rgb  out  12  pixel colour, 0 during blanking
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high while vga_rgb is a visible pixel
- frame_done  out  1  one-cycle pulse with the last visible pixel (639,479)

## Operation
- Counters: h_cnt 0..799 and v_cnt 0..524. h_cnt wraps to 0 and increments v_cnt. v_cnt wraps 524->0. Visible region is h_cnt<640 and v_cnt<480.
- Sync: hsync low for h_cnt 656..751. vsync low for v_cnt 490..491.
- Address generation uses no multiplier.
  - row_base (17 b) is cleared at v_cnt=0.
  - row_base += SRC_W at the end of every odd visible line (v_cnt[0]=1, h_cnt=799, v_cnt<479).
  - read_addr = row_base + h_cnt[9:1] + 1 in the visible region, else 0.
  - Range is 1..76800.
- Overlay latch: at h_cnt=0, v_cnt=0, latch h_centroid and stop_detect into frame-stable registers. The overlay never changes mid-frame.
- Colour select, evaluated in the output stage, highest priority first:
  1. Blanking -> 12'h000.
  2. overlay_en & latched stop & (x<4 | x>635 | y<4 | y>475) -> 12'hF00.
  3. overlay_en & latched centroid≠0 & (x[9:1]+1 == latched centroid) -> 12'h0F0.
  4. Otherwise data_in.
- frame_done asserts for the cycle in which pixel (639,479) appears on vga_rgb.

## Timing
- Pipeline stages: S0 counters -> S1 registered read_addr plus delayed x/y/visible/sync -> RD_LATENCY memory cycles -> output register.
- Counter-to-pin latency is 2+RD_LATENCY cycles (3 by default). hsync, vsync, video_on, frame_done and vga_rgb are all delayed identically, so they stay mutually aligned.
- Each source pixel is requested on 2 consecutive cycles and each source row on 2 consecutive lines. There is no read caching.
- Reset values: all counters 0, row_base 0, read_addr 0, vga_rgb 0, hsync 1, vsync 1, video_on 0, frame_done 0, all pipeline valid/sync delay registers at their inactive values, latched overlay 0.
- Reset asserted mid-frame: all of the above take effect immediately and asynchronously. After deassertion, scan restarts at (0,0). The first visible pixel reaches the pins 2+RD_LATENCY cycles later.
- Simultaneous end-of-line and end-of-frame (h=799, v=524): both counters wrap in the same cycle. row_base is cleared, not incremented.
- A h_centroid value above 320 never matches any column, so no marker is drawn.

## Structure
- Package ed_vga_pkg holds:
  - the timing constants (H_* and V_* values, line and frame totals)
  - the colour constants (BLACK 12'h000, RED 12'hF00, GREEN 12'h0F0)
  - SRC_W/SRC_H
- Sub-module ed_vga_timing contains h_cnt/v_cnt, sync decode, visible flag and end-of-line/end-of-frame strobes. The top level owns addressing, the overlay latch and the output pipeline.

## Test plan
- Reset then free-run: hsync period 800 cycles with a 96-cycle low pulse. vsync period 420000 cycles with a 1600-cycle low pulse. frame_done exactly once per frame.
- Buffer model with mem[a]=a[11:0]: read_addr sequence on line 0 is 1,1,2,2,…,320,320. Lines 0 and 1 are identical. Line 2 starts at 321. Line 479 ends at 76800. vga_rgb lags read_addr by 1+RD_LATENCY cycles.
- h_centroid=100 and overlay_en=1 latched at frame start: vga_rgb=12'h0F0 at x=198,199 on every visible line. Changing h_centroid mid-frame has no effect until the next frame.
- stop_detect=1 at frame start with overlay_en=1: 4-pixel 12'hF00 border on all edges, and the border overrides the marker at the corners. overlay_en=0 shows raw data only.
- Reset pulsed at (300,200): outputs go immediately to their reset values. The next visible output is (0,0) with address 1, after 3 cycles at RD_LATENCY=1.
- RD_LATENCY=2 build: sync and frame_done shift by one extra cycle, and colour data stays aligned with its pixel.
